// File: rtl/uart_apb_driver_if.sv
// rtl/uart_apb_driver_if.sv - APB requester-side signal bundle for the UART polling driver.
interface uart_apb_driver_if;
    logic        psel;
    logic        penable;
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready;
    logic [31:0] prdata;
    logic        pslverr;

    modport master (
        output psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        input  pready, prdata, pslverr
    );

    modport slave (
        input  psel, penable, paddr, pwrite, pwdata, pstrb, pprot,
        output pready, prdata, pslverr
    );
endinterface

// File: rtl/uart_apb_driver.sv
// rtl/uart_apb_driver.sv - APB master that configures a UART, polls its status and moves TX/RX bytes.
module uart_apb_driver #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [2:0]  CTRL_INIT = 3'b000,
    parameter int          POLL_GAP  = 4,
    parameter int          TIMEOUT   = 64
) (
    input  logic        clock,
    input  logic        rstn,
    output logic        out_psel,
    output logic        out_penable,
    output logic [31:0] out_paddr,
    output logic        out_pwrite,
    output logic [31:0] out_pwdata,
    output logic [3:0]  out_pstrb,
    output logic [2:0]  out_pprot,
    input  logic        out_pready,
    input  logic [31:0] out_prdata,
    input  logic        out_pslverr,
    input  logic        tx_valid,
    input  logic [7:0]  tx_data,
    output logic        tx_ready,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic        err
);
    typedef enum logic [2:0] {S_CFG, S_STAT, S_RD, S_WR, S_GAP} state_t;
    // PH_WAIT is the mandatory idle cycle before a SETUP (and the whole of GAP).
    typedef enum logic [1:0] {PH_WAIT, PH_SETUP, PH_ACCESS} phase_t;

    localparam logic [7:0] GAP_LAST  = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
    localparam logic [7:0] TOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    phase_t      ph_q, ph_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  tout_q, tout_d;
    logic        psel_q, psel_d;
    logic        penable_q, penable_d;
    logic [31:0] paddr_q, paddr_d;
    logic        pwrite_q, pwrite_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        err_q, err_d;

    logic in_access, done, tmo, stat_rd, stat_wr;
    logic unused_prdata;

    assign in_access = (ph_q == PH_ACCESS);
    assign done      = in_access && out_pready;
    assign tmo       = in_access && !out_pready && (tout_q == TOUT_LAST);
    assign stat_rd   = done && (state_q == S_STAT) && !out_pslverr
                       && !out_prdata[0] && !rx_valid_q;
    assign stat_wr   = done && (state_q == S_STAT) && !out_pslverr && !stat_rd
                       && tx_valid && !out_prdata[1];
    assign unused_prdata = ^out_prdata[31:8];

    always_ff @(posedge clock) begin
        if (!rstn) begin
            state_q    <= S_CFG;
            ph_q       <= PH_WAIT;
            gap_q      <= 8'd0;
            tout_q     <= 8'd0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
            paddr_q    <= 32'd0;
            pwrite_q   <= 1'b0;
            pwdata_q   <= 32'd0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'd0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_q       <= ph_d;
            gap_q      <= gap_d;
            tout_q     <= tout_d;
            psel_q     <= psel_d;
            penable_q  <= penable_d;
            paddr_q    <= paddr_d;
            pwrite_q   <= pwrite_d;
            pwdata_q   <= pwdata_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        gap_d   = gap_q;
        tout_d  = tout_q;
        case (ph_q)
            PH_WAIT: begin
                if (state_q == S_GAP) begin
                    // The last GAP cycle launches the status SETUP directly.
                    if (gap_q == GAP_LAST) begin
                        state_d = S_STAT;
                        ph_d    = PH_SETUP;
                        gap_d   = 8'd0;
                    end else begin
                        gap_d = gap_q + 8'd1;
                    end
                end else begin
                    ph_d = PH_SETUP;
                end
            end
            PH_SETUP: begin
                ph_d   = PH_ACCESS;
                tout_d = 8'd0;
            end
            PH_ACCESS: begin
                if (done) begin
                    ph_d  = PH_WAIT;
                    gap_d = 8'd0;
                    if (state_q == S_STAT) begin
                        state_d = stat_rd ? S_RD : (stat_wr ? S_WR : S_GAP);
                    end else begin
                        state_d = S_STAT;
                    end
                end else if (tmo) begin
                    ph_d    = PH_WAIT;
                    state_d = S_GAP;
                    gap_d   = 8'd0;
                end else begin
                    tout_d = tout_q + 8'd1;
                end
            end
            default: ph_d = PH_WAIT;
        endcase
    end

    always_comb begin
        psel_d     = (ph_d == PH_SETUP) || (ph_d == PH_ACCESS);
        penable_d  = (ph_d == PH_ACCESS);
        paddr_d    = paddr_q;
        pwrite_d   = pwrite_q;
        pwdata_d   = pwdata_q;
        rx_valid_d = rx_valid_q;
        rx_data_d  = rx_data_q;
        err_d      = err_q | (done && out_pslverr) | tmo;
        if (stat_wr) begin
            pwdata_d = {24'd0, tx_data};
        end
        if (ph_d == PH_SETUP) begin
            paddr_d  = BASE_ADDR + (((state_d == S_RD) || (state_d == S_WR)) ? 32'd0 : 32'd4);
            pwrite_d = (state_d == S_CFG) || (state_d == S_WR);
            if (state_d == S_CFG) begin
                pwdata_d = {29'd0, CTRL_INIT};
            end
        end
        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end
        if (done && (state_q == S_RD) && !out_pslverr) begin
            rx_valid_d = 1'b1;
            rx_data_d  = out_prdata[7:0];
        end
    end

    assign out_psel    = psel_q;
    assign out_penable = penable_q;
    assign out_paddr   = paddr_q;
    assign out_pwrite  = pwrite_q;
    assign out_pwdata  = pwdata_q;
    assign out_pstrb   = 4'b0001;
    assign out_pprot   = 3'b000;
    assign tx_ready    = rstn && stat_wr;
    assign rx_valid    = rx_valid_q;
    assign rx_data     = rx_data_q;
    assign err         = err_q;
endmodule

// File: doc/uart_apb_driver.md
UART_APB_DRIVER -- requirements
Module: uart_apb_driver

Interface
REQ-001 The block SHALL have the following parameters (name, default, meaning):
- BASE_ADDR, 32'h0000_0000, APB base address of the UART.
- CTRL_INIT, 3'b000, value written to the control register after reset.
- POLL_GAP, 4, idle cycles between status polls when no work is pending (valid range 0..255).
- TIMEOUT, 64, maximum ACCESS cycles waited for out_pready (valid range 1..255).

REQ-002 The block SHALL have the following ports (name, direction, width, meaning):
- clock, in, 1, single clock; all logic on its rising edge.
- rstn, in, 1, synchronous, active-low reset.
- out_psel, out, 1, APB select.
- out_penable, out, 1, APB enable.
- out_paddr, out, 32, APB address.
- out_pwrite, out, 1, APB write.
- out_pwdata, out, 32, APB write data.
- out_pstrb, out, 4, APB strobes; constant 4'b0001.
- out_pprot, out, 3, APB protection; constant 3'b000.
- out_pready, in, 1, APB ready.
- out_prdata, in, 32, APB read data.
- out_pslverr, in, 1, APB error.
- tx_valid, in, 1, a byte is offered for transmission.
- tx_data, in, 8, the byte offered for transmission.
- tx_ready, out, 1, the offered byte is accepted this cycle.
- rx_valid, out, 1, a received byte is held.
- rx_data, out, 8, the received byte.
- rx_ready, in, 1, the sink consumes the held byte.
- err, out, 1, sticky error flag: pslverr seen or timeout.

Function
REQ-003 UART register map SHALL be:
- BASE_ADDR+0x00: data register; write = TX push, read = RX pop.
- BASE_ADDR+0x04: control on write (bits [2:0]); status on read (bit0 rx_empty, bit1 tx_full).

REQ-004 Every APB transfer SHALL be one SETUP cycle (psel=1, penable=0), then ACCESS cycles (psel=1, penable=1) until out_pready=1; paddr, pwrite and pwdata SHALL be stable from SETUP through the last ACCESS cycle.

REQ-005 Between transfers, psel and penable SHALL be 0; there SHALL be no back-to-back transfers, i.e. at least one idle cycle after each completion.

REQ-006 The FSM SHALL have the states CFG, STAT, RD, WR and GAP; each of CFG, STAT, RD and WR carries a SETUP/ACCESS phase bit.

REQ-007 After reset the FSM SHALL enter CFG: write {29'b0, CTRL_INIT} to +0x04, then go to STAT.

REQ-008 STAT SHALL read +0x04; in the completion cycle, the captured status selects the next state with this priority:
- rx_empty=0 and the RX buffer is empty -> RD;
- else tx_valid=1 and tx_full=0 -> WR;
- else -> GAP.

REQ-009 tx_ready SHALL be 1 only in the STAT completion cycle that selects WR; in that cycle tx_data SHALL be latched into out_pwdata[7:0] with [31:8]=0.

REQ-010 RD SHALL read +0x00; on completion, out_prdata[7:0] SHALL load the RX buffer and set rx_valid=1 in the next cycle.

REQ-011 The RX buffer is single-entry: rx_valid SHALL stay 1 with rx_data stable until a cycle with rx_ready=1, and SHALL clear in the following cycle.

REQ-012 Completions SHALL route as follows:
- RD -> STAT.
- WR -> STAT.
- GAP SHALL count POLL_GAP idle cycles, then -> STAT; with POLL_GAP=0 it lasts one cycle.

REQ-013 If out_pslverr=1 at a completion, err SHALL be set and the transfer treated as complete:
- a RD SHALL NOT load the RX buffer;
- a STAT SHALL go to GAP.

REQ-014 If TIMEOUT ACCESS cycles pass without out_pready:
- drop psel/penable the next cycle;
- set err;
- go to GAP;
- RX buffer unchanged; a WR byte is discarded.

REQ-015 err SHALL clear only on reset.

REQ-016 The block SHALL NOT use out_pready or out_prdata outside ACCESS cycles.

REQ-017 rx_ready with rx_valid=0 SHALL be ignored.

Reset
REQ-018 With rstn=0 at a rising edge:
- outputs: out_psel=0, out_penable=0, out_paddr=0, out_pwrite=0, out_pwdata=0, tx_ready=0, rx_valid=0, rx_data=0, err=0.
- internal: timeout and gap counters cleared; FSM in CFG SETUP-pending.
- The first SETUP SHALL appear in the second cycle after release.

REQ-019 Reset mid-transfer SHALL abandon the transfer immediately, with no completion side effects.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Reset release, CTRL_INIT=3'b101, slave pready=1 -> first transfer is a write of 0x5 to 0x04, then a read of 0x04.
- Status 0x1 (rx_empty, tx not full), tx_valid=1, tx_data=0x41 -> tx_ready pulses 1 cycle; write of 0x0000_0041 to 0x00.
- Status 0x0, rx_ready=0, prdata=0x5A -> rx_valid=1, rx_data=0x5A held; further status 0x0 reads go to WR/GAP, with no second RD until rx_ready.
- Status 0x2 (tx_full), tx_valid=1 -> no tx_ready and no data write; GAP of POLL_GAP cycles, then re-poll.
- pready held 0 with TIMEOUT=8 -> psel drops after 8 ACCESS cycles; err=1; STAT resumes after GAP.
- pslverr=1 on RD -> err=1; rx_valid stays 0.
